rd_req_engine: RTL and testbench

// Generates all CCI-P read requests for the AFU: it polls the CPU control word while the AFU waits for
// a command, then issues one run's data-CL reads. Feeds the header-generation/c0Tx register stage
// (rd_valid/rd_addr/rd_mdata); ctrl responses come back via ctrl_resp_valid from the c0Rx handler.

---
 rtl/rd_req_engine.sv | 133 +++++++++++++
 tb/tb_rd_req_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_req_engine.sv
// CCI-P read request generator: polls the CPU control word while the AFU is idle,
// then streams one run's data-CL reads, with all outputs driven from flops.
module rd_req_engine #(
  parameter logic [15:0] READ_CTRL_MDATA = 16'h0001,
  parameter logic [15:0] READ_RUN_MDATA  = 16'h0002,
  parameter int unsigned POLL_TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_en,
  input  logic [41:0] ctrl_addr,
  input  logic        ctrl_resp_valid,
  input  logic        run_start,
  input  logic [41:0] run_base_addr,
  input  logic [31:0] run_num_cls,
  input  logic        stall,
  output logic        rd_valid,
  output logic [41:0] rd_addr,
  output logic [15:0] rd_mdata,
  output logic        run_issue_done,
  output logic [31:0] reqs_issued
);

  localparam int TW = (POLL_TIMEOUT > 2) ? $clog2(POLL_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POLL_ISSUE,
    POLL_WAIT,
    RUN,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [41:0] base, base_next;
  logic [31:0] num, num_next;
  logic [31:0] reqs_next;
  logic        done_next;
  logic        issue;
  logic [41:0] issue_addr;
  logic [15:0] issue_mdata;
  logic        start_run;

  // run_start is honoured everywhere except while a run is already being issued
  assign start_run = run_start && (state != RUN);

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    base_next   = base;
    num_next    = num;
    reqs_next   = reqs_issued;
    done_next   = run_issue_done;
    issue       = 1'b0;
    issue_addr  = rd_addr;
    issue_mdata = rd_mdata;
    if (start_run) begin
      state_next = RUN;
      base_next  = run_base_addr;
      num_next   = run_num_cls;
      reqs_next  = '0;
      done_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (poll_en) state_next = POLL_ISSUE;
        end
        POLL_ISSUE: begin
          if (!poll_en) begin
            state_next = IDLE;
          end else if (!stall) begin
            issue       = 1'b1;
            issue_addr  = ctrl_addr;
            issue_mdata = READ_CTRL_MDATA;
            timer_next  = '0;
            state_next  = POLL_WAIT;
          end
        end
        POLL_WAIT: begin
          timer_next = timer + TW'(1);
          if (!poll_en) begin
            state_next = IDLE;
          end else if (ctrl_resp_valid || (timer == TIMEOUT_LAST)) begin
            state_next = POLL_ISSUE;
          end
        end
        RUN: begin
          // Completion is checked before issuing so a zero-length run issues nothing
          if (reqs_issued == num) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (!stall) begin
            issue       = 1'b1;
            issue_addr  = base + {10'd0, reqs_issued};
            issue_mdata = READ_RUN_MDATA;
            reqs_next   = reqs_issued + 32'd1;
          end
        end
        DONE: begin
          if (poll_en) state_next = POLL_ISSUE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      base           <= '0;
      num            <= '0;
      reqs_issued    <= '0;
      run_issue_done <= 1'b0;
      rd_valid       <= 1'b0;
      rd_addr        <= '0;
      rd_mdata       <= '0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      base           <= base_next;
      num            <= num_next;
      reqs_issued    <= reqs_next;
      run_issue_done <= done_next;
      rd_valid       <= issue;
      rd_addr        <= issue_addr;
      rd_mdata       <= issue_mdata;
    end
  end

endmodule

// File: tb/tb_rd_req_engine.sv
// Self-checking bench for rd_req_engine: every request is matched against a
// scoreboard queue of expected {addr, mdata}; run cases come from a vector table.
module tb_rd_req_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        poll_en;
  logic [41:0] ctrl_addr;
  logic        ctrl_resp_valid;
  logic        run_start;
  logic [41:0] run_base_addr;
  logic [31:0] run_num_cls;
  logic        stall;
  logic        rd_valid;
  logic [41:0] rd_addr;
  logic [15:0] rd_mdata;
  logic        run_issue_done;
  logic [31:0] reqs_issued;

  rd_req_engine dut (
    .clk(clk),
    .reset(reset),
    .poll_en(poll_en),
    .ctrl_addr(ctrl_addr),
    .ctrl_resp_valid(ctrl_resp_valid),
    .run_start(run_start),
    .run_base_addr(run_base_addr),
    .run_num_cls(run_num_cls),
    .stall(stall),
    .rd_valid(rd_valid),
    .rd_addr(rd_addr),
    .rd_mdata(rd_mdata),
    .run_issue_done(run_issue_done),
    .reqs_issued(reqs_issued)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [41:0] addr;
    logic [15:0] mdata;
  } req_t;

  typedef struct {
    logic [41:0] base;
    logic [31:0] num;
    int          stall_at;
    int          stall_len;
    logic [41:0] exp_last;
    int          exp_reqs;
  } vec_t;

  req_t exp_q[$];
  req_t mon_exp;
  vec_t vecs[5];
  int   checks = 0;
  int   failures = 0;
  int   rd_count = 0;
  logic [41:0] last_addr = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      rd_count++;
      last_addr = rd_addr;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_req: got addr 0x%0h mdata 0x%0h, expected no request", rd_addr, rd_mdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rd_addr, rd_mdata} !== mon_exp) begin
          failures++;
          $display("[TB] FAIL req_match: got addr 0x%0h mdata 0x%0h, expected addr 0x%0h mdata 0x%0h",
                   rd_addr, rd_mdata, mon_exp.addr, mon_exp.mdata);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_reqs(input string name, input int target, input int budget);
    int n = 0;
    while (rd_count < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(name, 64'(rd_count), 64'(target));
  endtask

  task automatic push_exp(input logic [41:0] addr, input logic [15:0] mdata);
    req_t r;
    r.addr  = addr;
    r.mdata = mdata;
    exp_q.push_back(r);
  endtask

  // One run: start pulse, expected addresses queued, stall window driven per decision cycle
  task automatic applyStimulus(input vec_t v);
    int  start_count = rd_count;
    logic stalled;
    for (int i = 0; i < v.exp_reqs; i++) push_exp(v.base + 42'(i), 16'h0002);
    run_base_addr = v.base;
    run_num_cls   = v.num;
    run_start     = 1'b1;
    tick(1);
    run_start     = 1'b0;
    run_base_addr = 42'h155_5555_5555;
    run_num_cls   = 32'hDEAD;
    for (int cyc = 0; cyc < 100 && run_issue_done !== 1'b1; cyc++) begin
      stalled = (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len);
      stall = stalled;
      tick(1);
      if (stalled) checkOutput("stall_quiet", 64'(rd_valid), 64'd0);
    end
    stall = 1'b0;
    checkOutput("run_done", 64'(run_issue_done), 64'd1);
    checkOutput("reqs_issued", 64'(reqs_issued), 64'(v.exp_reqs));
    checkOutput("run_req_count", 64'(rd_count - start_count), 64'(v.exp_reqs));
    if (v.exp_reqs > 0) checkOutput("run_last_addr", 64'(last_addr), 64'(v.exp_last));
    checkOutput("run_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   base_count;
    vec_t v;

    vecs[0] = '{base: 42'h2000,          num: 32'd4, stall_at: -1, stall_len: 0, exp_last: 42'h2003,          exp_reqs: 4};
    vecs[1] = '{base: 42'h5000,          num: 32'd8, stall_at: 2,  stall_len: 5, exp_last: 42'h5007,          exp_reqs: 8};
    vecs[2] = '{base: 42'h123,           num: 32'd0, stall_at: -1, stall_len: 0, exp_last: 42'h0,             exp_reqs: 0};
    vecs[3] = '{base: 42'h3FF_FFFF_FFFF, num: 32'd2, stall_at: -1, stall_len: 0, exp_last: 42'h0,             exp_reqs: 2};
    vecs[4] = '{base: 42'h7_0000,        num: 32'd3, stall_at: 0,  stall_len: 2, exp_last: 42'h7_0002,        exp_reqs: 3};

    reset = 1'b1;
    poll_en = 1'b0;
    ctrl_addr = '0;
    ctrl_resp_valid = 1'b0;
    run_start = 1'b0;
    run_base_addr = '0;
    run_num_cls = '0;
    stall = 1'b0;
    tick(3);
    checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("reset_rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("reset_rd_mdata", 64'(rd_mdata), 64'd0);
    checkOutput("reset_done", 64'(run_issue_done), 64'd0);
    checkOutput("reset_reqs", 64'(reqs_issued), 64'd0);
    reset = 1'b0;
    tick(2);

    $display("[TB] poll and timeout");
    ctrl_addr = 42'h100;
    base_count = rd_count;
    push_exp(42'h100, 16'h0001);
    poll_en = 1'b1;
    wait_reqs("poll_first", base_count + 1, 10);
    tick(255);
    checkOutput("poll_no_early_reissue", 64'(rd_count), 64'(base_count + 1));
    push_exp(42'h100, 16'h0001);
    wait_reqs("poll_timeout_reissue", base_count + 2, 5);

    $display("[TB] poll response");
    tick(10);
    push_exp(42'h100, 16'h0001);
    ctrl_resp_valid = 1'b1;
    tick(1);
    ctrl_resp_valid = 1'b0;
    wait_reqs("poll_resp_reissue", base_count + 3, 2);
    poll_en = 1'b0;
    tick(5);
    ctrl_resp_valid = 1'b1;
    tick(1);
    ctrl_resp_valid = 1'b0;
    tick(300);
    checkOutput("poll_stopped", 64'(rd_count), 64'(base_count + 3));

    $display("[TB] run vectors");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    $display("[TB] poll from done");
    base_count = rd_count;
    ctrl_addr = 42'h240;
    push_exp(42'h240, 16'h0001);
    poll_en = 1'b1;
    wait_reqs("done_poll", base_count + 1, 10);
    checkOutput("done_held_in_poll", 64'(run_issue_done), 64'd1);
    poll_en = 1'b0;
    tick(3);

    $display("[TB] reset mid-run");
    base_count = rd_count;
    for (int i = 0; i < 10; i++) push_exp(42'h8000 + 42'(i), 16'h0002);
    run_base_addr = 42'h8000;
    run_num_cls = 32'd10;
    run_start = 1'b1;
    tick(1);
    run_start = 1'b0;
    wait_reqs("abort_three_issued", base_count + 3, 20);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("abort_rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("abort_rd_mdata", 64'(rd_mdata), 64'd0);
    checkOutput("abort_done", 64'(run_issue_done), 64'd0);
    checkOutput("abort_reqs", 64'(reqs_issued), 64'd0);
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    tick(20);
    checkOutput("abort_quiet", 64'(rd_count), 64'(base_count + 3));
    v = '{base: 42'h50, num: 32'd1, stall_at: -1, stall_len: 0, exp_last: 42'h50, exp_reqs: 1};
    applyStimulus(v);

    tick(5);
    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
